// File: rtl/hazard_scoreboard.sv
// Load-use / multi-cycle-latency hazard detector sitting beside ID.
// Keeps one countdown per architectural register and decides issue versus stall each cycle.
module hazard_scoreboard #(
  parameter int REG_AW     = 4,
  parameter int LOAD_STALL = 1,
  parameter int MUL_STALL  = 2,
  parameter int STAT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic                 id_kill,
  input  logic [REG_AW-1:0]    id_rs1,
  input  logic [REG_AW-1:0]    id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [REG_AW-1:0]    id_rd,
  input  logic                 id_reg_write,
  input  logic [1:0]           id_op_class,
  input  logic                 pipe_freeze,
  input  logic                 stat_clr,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 idex_flush,
  output logic [2**REG_AW-1:0] busy_vec,
  output logic [STAT_W-1:0]    stall_count
);

  localparam int NUM_REGS = 2 ** REG_AW;
  localparam int MAX_LAT  = (LOAD_STALL > MUL_STALL) ? LOAD_STALL : MUL_STALL;
  localparam int CW       = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

  logic [NUM_REGS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [STAT_W-1:0]           stall_q, stall_d;

  logic [CW-1:0] lat_id;
  logic [CW-1:0] cnt_rs1, cnt_rs2, cnt_rd;
  logic          raw1, raw2, waw, hazard, issue, load_en;

  always_comb begin
    lat_id = '0;
    case (id_op_class)
      2'd1:    lat_id = CW'(LOAD_STALL);
      2'd2:    lat_id = CW'(MUL_STALL);
      default: lat_id = '0;
    endcase
  end

  // Register 0 is never busy regardless of what its storage slot holds.
  assign cnt_rs1 = (id_rs1 == '0) ? '0 : cnt_q[id_rs1];
  assign cnt_rs2 = (id_rs2 == '0) ? '0 : cnt_q[id_rs2];
  assign cnt_rd  = (id_rd  == '0) ? '0 : cnt_q[id_rd];

  assign raw1   = id_rs1_used & (cnt_rs1 != '0);
  assign raw2   = id_rs2_used & (cnt_rs2 != '0);
  // Equal count is safe: the new write lands no earlier than the pending one.
  assign waw    = id_reg_write & (cnt_rd > lat_id);
  assign hazard = id_valid & ~id_kill & (raw1 | raw2 | waw);
  assign issue  = id_valid & ~id_kill & ~hazard & ~pipe_freeze;
  assign load_en = issue & id_reg_write & (id_rd != '0);

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    idex_flush = 1'b0;
    if (pipe_freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (hazard) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!pipe_freeze) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CW'(1);
        if (load_en && (id_rd == REG_AW'(r))) cnt_d[r] = lat_id;
      end
    end
    cnt_d[0] = '0;
  end

  always_comb begin
    stall_d = stall_q;
    if (stat_clr) begin
      stall_d = '0;
    end else if (hazard && !pipe_freeze && (stall_q != {STAT_W{1'b1}})) begin
      stall_d = stall_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < NUM_REGS; r++) busy_vec[r] = (cnt_q[r] != '0);
  end

  assign stall_count = stall_q;

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised load-use and multi-cycle-latency hazard detector for the AK-16b pipeline. It sits beside the ID stage and keeps one registered countdown per architectural register for writes still in flight. From these counters it decides, each cycle, whether the instruction in ID may issue or must stall with a bubble in ID/EX. It generalises single-cycle load-use detection to configurable register count, per-class latencies, WAW ordering, pipeline freeze and a stall-cycle performance counter.

## Interface
Parameters:
- REG_AW, 4: register address width; NUM_REGS = 2**REG_AW; register 0 is hard-wired zero and never busy.
- LOAD_STALL, 1: bubbles a dependent needs after a load (class 1).
- MUL_STALL, 2: bubbles a dependent needs after a multi-cycle op (class 2).
- STAT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_kill  in  1  ID instruction squashed (branch redirect): no issue, no hazard.
- id_rs1, id_rs2  in  REG_AW  source register addresses.
- id_rs1_used, id_rs2_used  in  1  source is actually read.
- id_rd  in  REG_AW  destination register.
- id_reg_write  in  1  instruction writes id_rd.
- id_op_class  in  2  0 ALU (0 stalls), 1 load, 2 multi-cycle, 3 treated as ALU.
- pipe_freeze  in  1  global memory stall: whole pipeline holds.
- stat_clr  in  1  synchronous clear of stall_count.
- pc_write  out  1  1 = PC advances.
- ifid_write  out  1  1 = IF/ID updates.
- idex_flush  out  1  1 = insert NOP into ID/EX.
- busy_vec  out  NUM_REGS  bit r = counter r nonzero.
- stall_count  out  STAT_W  saturating count of hazard-stall cycles.

## Operation
- State: cnt[r], width clog2(max(LOAD_STALL,MUL_STALL)+1), for r = 1..NUM_REGS-1. cnt[0] is constant 0.
- lat(class) = LOAD_STALL for class 1, MUL_STALL for class 2, 0 otherwise.
- raw1 = id_rs1_used & id_rs1≠0 & cnt[id_rs1]≠0. raw2 is the same for rs2.
- waw = id_reg_write & id_rd≠0 & cnt[id_rd] > lat(id_op_class). An equal count is not a hazard.
- hazard = id_valid & ~id_kill & (raw1 | raw2 | waw).
- Outputs (combinational from state and inputs):
  - pipe_freeze=1: pc_write=0, ifid_write=0, idex_flush=0 (freeze takes priority).
  - Otherwise hazard=1: pc_write=0, ifid_write=0, idex_flush=1.
  - Otherwise: pc_write=1, ifid_write=1, idex_flush=0.
- issue = id_valid & ~id_kill & ~hazard & ~pipe_freeze.
- Counter update when pipe_freeze=0:
  - Every nonzero cnt decrements by 1.
  - Then, if issue & id_reg_write & id_rd≠0, cnt[id_rd] is loaded with lat(id_op_class); the load overrides the decrement.
  - An ALU op therefore clears a pending count on its rd. This is legal only because waw guarantees the older write has already finished.
- pipe_freeze=1: all counters hold and nothing issues.
- stall_count:
  - stat_clr has priority and sets it to 0.
  - Otherwise it increments when hazard & ~pipe_freeze, saturating at all-ones.
- Reset: all cnt = 0, stall_count = 0. Consequently busy_vec = 0, pc_write = 1, ifid_write = 1, idex_flush = 0. Reset mid-stall abandons all pending counts.

## Timing
- Decisions are made in the same cycle from registered counters, with zero latency to the stall outputs.
- A load issued at edge t sets cnt = LOAD_STALL, visible from t. A dependent in ID sees exactly LOAD_STALL stall cycles, then issues.
- Back-to-back independent instructions issue every cycle.
- A stalled instruction is re-evaluated each cycle with no extra penalty.
- Freeze cycles do not consume bubbles: countdown resumes where it stopped.
- Simultaneous issue to rd and decrement of rd: the load wins.
- id_kill together with a matching source causes no stall and no counter load.
- Max counter value equals max(LOAD_STALL, MUL_STALL). No wrap-around is possible.

## Test plan
- Reset, then idle -> pc_write=1, ifid_write=1, idex_flush=0, busy_vec=0, stall_count=0.
- Load to R3 issues, next ID reads R3 (rs1_used=1), defaults -> exactly 1 cycle with idex_flush=1, then issue; stall_count=1. Same sequence with rd=R0 -> no stall.
- Multi-cycle op to R5, next ID reads R5 via rs2 -> 2 stall cycles. Insert pipe_freeze for 3 cycles mid-stall -> still 2 flush cycles total, with all outputs 0 during the freeze.
- Multi-cycle op to R7, next ID is an ALU op writing R7 with no sources -> WAW stall for 2 cycles. A load to R7 in the same slot -> 1 stall (cnt 2 > 1), then issue.
- Load to R2, next ID reads R2 with id_kill=1 -> no stall, R2 counter still drains to 0 one cycle later.
- Force 2**STAT_W+3 hazard cycles -> stall_count saturates at all-ones. stat_clr during a hazard -> 0 next cycle.
